// File: rtl/button_conditioner_pkg.sv
// Shared constants for the Basys combo-lock button front end: channel map,
// board clock rate and default debounce / auto-repeat timing.
package button_conditioner_pkg;

  localparam int CLK_HZ        = 100_000_000;
  localparam int N_BTN_DEFAULT = 5;

  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;
  localparam int BTN_D = 4;

  // 10 ms debounce, 0.5 s before the first repeat, then 5 repeats per second.
  localparam int DEFAULT_DEBOUNCE_CYCLES = CLK_HZ / 100;
  localparam int DEFAULT_REPEAT_DELAY    = CLK_HZ / 2;
  localparam int DEFAULT_REPEAT_PERIOD   = CLK_HZ / 5;

  localparam logic [N_BTN_DEFAULT-1:0] DEFAULT_REPEAT_MASK =
    N_BTN_DEFAULT'((1 << BTN_L) | (1 << BTN_R));

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'd0,
    EVT_RELEASE = 2'd1,
    EVT_PULSE   = 2'd2
  } btn_evt_e;

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle between the raw push-buttons (master) and the conditioner (slave).
interface button_conditioner_if
  import button_conditioner_pkg::*;
#(
  parameter int N_BTN = N_BTN_DEFAULT
);

  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_pulse;

  modport master (
    output btn_raw,
    input  btn_level, btn_press, btn_release, btn_pulse
  );

  modport slave (
    input  btn_raw,
    output btn_level, btn_press, btn_release, btn_pulse
  );

endinterface

// File: rtl/button_conditioner_cell.sv
// One button channel: 2-flop synchroniser, restartable debounce window,
// registered press/release edges and an optional auto-repeat timer.
module btn_debounce_cell #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 20_000_000,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic pulse_o
);

  localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCNT_W  = $clog2(RPT_MAX + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);

  logic [1:0]        sync_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [RCNT_W-1:0] rcnt_q;
  logic              first_q;
  logic              level_q, press_q, release_q, pulse_q;

  logic              differ_d, toggle_d, rpt_hit_d;
  logic [RCNT_W-1:0] rpt_last_d;

  // NOTE: every signal is assigned on every pass, so no latch can be inferred.
  always_comb begin
    differ_d   = sync_q[1] ^ level_q;
    toggle_d   = differ_d && (cnt_q == CNT_LAST);
    rpt_last_d = first_q ? DELAY_LAST : PERIOD_LAST;
    rpt_hit_d  = (rcnt_q == rpt_last_d);
  end

  // NOTE: non-blocking updates let each flop see only pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      rcnt_q    <= '0;
      first_q   <= 1'b0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], raw_i};
      press_q   <= 1'b0;
      release_q <= 1'b0;
      pulse_q   <= 1'b0;

      if (!differ_d) begin
        cnt_q <= '0;
      end else if (toggle_d) begin
        cnt_q     <= '0;
        level_q   <= ~level_q;
        press_q   <= ~level_q;
        release_q <= level_q;
        pulse_q   <= ~level_q;
        rcnt_q    <= '0;
        first_q   <= 1'b1;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      // Repeat timer only runs while held; the release edge is excluded above.
      if (REPEAT_EN && level_q && !toggle_d) begin
        if (rpt_hit_d) begin
          pulse_q <= 1'b1;
          rcnt_q  <= '0;
          first_q <= 1'b0;
        end else begin
          rcnt_q <= rcnt_q + RCNT_W'(1);
        end
      end
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign pulse_o   = pulse_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions all push-buttons: one independent debounce cell per channel,
// auto-repeat enabled only on the channels selected by REPEAT_MASK.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int              N_BTN           = N_BTN_DEFAULT,
  parameter int              DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int              REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int              REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD,
  parameter logic [N_BTN-1:0] REPEAT_MASK    = N_BTN'(DEFAULT_REPEAT_MASK)
) (
  input logic                  clk,
  input logic                  rst,
  button_conditioner_if.slave  bus
);

  logic [N_BTN-1:0] level_w, press_w, release_w, pulse_w;

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .REPEAT_EN       (REPEAT_MASK[i])
    ) u_cell (
      .clk       (clk),
      .rst       (rst),
      .raw_i     (bus.btn_raw[i]),
      .level_o   (level_w[i]),
      .press_o   (press_w[i]),
      .release_o (release_w[i]),
      .pulse_o   (pulse_w[i])
    );
  end

  assign bus.btn_level   = level_w;
  assign bus.btn_press   = press_w;
  assign bus.btn_release = release_w;
  assign bus.btn_pulse   = pulse_w;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: expected pulse events are queued
// from the stimulus timing and matched against every pulse the DUT emits.
module tb_button_conditioner;
  import button_conditioner_pkg::*;

  localparam int             NB   = 5;
  localparam int             DB   = 4;
  localparam int             RD   = 10;
  localparam int             RP   = 3;
  localparam logic [NB-1:0]  MASK = 5'b00100;
  localparam int             LAT  = DB + 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_q[$];

  button_conditioner_if #(.N_BTN(NB)) bus ();

  button_conditioner #(
    .N_BTN           (NB),
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP),
    .REPEAT_MASK     (MASK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Event key orders events by cycle, then kind, then channel.
  function automatic int evt_key(input int c, input btn_evt_e kind, input int ch);
    return c * 32 + int'(kind) * 8 + ch;
  endfunction

  task automatic push_evt(input int c, input btn_evt_e kind, input int ch);
    exp_q.push_back(evt_key(c, kind, ch));
    exp_q.sort();
  endtask

  // Raw held from just after edge r to just after edge f (f - r >= DB).
  task automatic expect_hold(input int ch, input int r, input int f);
    int p;
    p = r + LAT;
    push_evt(p, EVT_PRESS, ch);
    push_evt(p, EVT_PULSE, ch);
    if (MASK[ch])
      for (int t = p + RD; t < f + LAT; t += RP) push_evt(t, EVT_PULSE, ch);
    push_evt(f + LAT, EVT_RELEASE, ch);
  endtask

  task automatic scan(input logic [NB-1:0] v, input btn_evt_e kind);
    for (int ch = 0; ch < NB; ch++) begin
      if (v[ch]) begin
        int key;
        key = evt_key(cyc, kind, ch);
        if (exp_q.size() == 0) check("unexpected_event", key, -1);
        else                   check("event", key, exp_q.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      scan(bus.btn_press,   EVT_PRESS);
      scan(bus.btn_release, EVT_RELEASE);
      scan(bus.btn_pulse,   EVT_PULSE);
    end
  end

  task automatic wait_to(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  task automatic at_edge(input int n);
    wait_to(n - 1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n, input string tag);
    wait_to(n);
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int r;
    bus.btn_raw = '0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_level",   int'(bus.btn_level),   0);
    check("rst_press",   int'(bus.btn_press),   0);
    check("rst_release", int'(bus.btn_release), 0);
    check("rst_pulse",   int'(bus.btn_pulse),   0);
    rst = 1'b0;

    // Clean press on btnC
    at_edge(cyc + 2);
    c0 = cyc;
    bus.btn_raw[BTN_C] = 1'b1;
    expect_hold(BTN_C, c0, c0 + 20);
    wait_to(c0 + LAT - 1);
    check("clean_level_early", int'(bus.btn_level[BTN_C]), 0);
    wait_to(c0 + LAT);
    check("clean_level", int'(bus.btn_level[BTN_C]), 1);
    at_edge(c0 + 20);
    bus.btn_raw[BTN_C] = 1'b0;
    drain(c0 + 20 + LAT + 3, "clean_leftover");
    check("clean_level_off", int'(bus.btn_level[BTN_C]), 0);

    // Bouncing btnU: 2-cycle toggles, final rise at c0+12
    at_edge(cyc + 2);
    c0 = cyc;
    bus.btn_raw[BTN_U] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      at_edge(c0 + 2 * k);
      bus.btn_raw[BTN_U] = ~k[0];
    end
    expect_hold(BTN_U, c0 + 12, c0 + 24);
    wait_to(c0 + 12 + LAT - 1);
    check("bounce_level_early", int'(bus.btn_level[BTN_U]), 0);
    wait_to(c0 + 12 + LAT);
    check("bounce_level", int'(bus.btn_level[BTN_U]), 1);
    at_edge(c0 + 24);
    bus.btn_raw[BTN_U] = 1'b0;
    drain(c0 + 24 + LAT + 3, "bounce_leftover");

    // 3-cycle glitch on btnR never reaches the outputs
    at_edge(cyc + 2);
    c0 = cyc;
    bus.btn_raw[BTN_R] = 1'b1;
    at_edge(c0 + 3);
    bus.btn_raw[BTN_R] = 1'b0;
    for (int k = c0 + 4; k <= c0 + 12; k += 2) begin
      wait_to(k);
      check("glitch_level", int'(bus.btn_level[BTN_R]), 0);
    end
    drain(c0 + 14, "glitch_leftover");

    // Auto-repeat on btnL held 30 cycles
    at_edge(cyc + 2);
    c0 = cyc;
    bus.btn_raw[BTN_L] = 1'b1;
    expect_hold(BTN_L, c0, c0 + 30);
    at_edge(c0 + 30);
    bus.btn_raw[BTN_L] = 1'b0;
    drain(c0 + 30 + LAT + RD, "repeat_leftover");

    // Reset in the middle of a btnC hold
    at_edge(cyc + 2);
    c0 = cyc;
    bus.btn_raw[BTN_C] = 1'b1;
    push_evt(c0 + LAT, EVT_PRESS, BTN_C);
    push_evt(c0 + LAT, EVT_PULSE, BTN_C);
    wait_to(c0 + LAT + 2);
    check("hold_level", int'(bus.btn_level[BTN_C]), 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_level", int'(bus.btn_level), 0);
    check("midrst_any", int'(bus.btn_press | bus.btn_release | bus.btn_pulse), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    r = cyc;
    expect_hold(BTN_C, r, r + 12);
    wait_to(r + LAT - 1);
    check("rerun_level_early", int'(bus.btn_level[BTN_C]), 0);
    wait_to(r + LAT);
    check("rerun_press", int'(bus.btn_press[BTN_C]), 1);
    at_edge(r + 12);
    bus.btn_raw[BTN_C] = 1'b0;
    drain(r + 12 + LAT + 3, "rerun_leftover");

    // All channels rise together
    at_edge(cyc + 2);
    c0 = cyc;
    bus.btn_raw = '1;
    for (int ch = 0; ch < NB; ch++) expect_hold(ch, c0, c0 + 12);
    wait_to(c0 + LAT);
    check("simul_press", int'(bus.btn_press), 31);
    at_edge(c0 + 12);
    bus.btn_raw = '0;
    drain(c0 + 12 + LAT + 3, "simul_leftover");
    check("final_level", int'(bus.btn_level), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
